data_memory_line: RTL and testbench
===================================

# data_memory_line

Line-granular data memory that is the responder end of the data cache's memory interface. Accepts one 256-bit line read or write request at a time, holds it for a fixed programmable latency, then completes it with a single-cycle acknowledge. Sits between the data cache controller and the top level. Replaces any ad-hoc memory model so cache miss and write-back timing is deterministic and testable.

## Interface
- LATENCY, 10, cycles from request acceptance to ack; legal range 1..255
- DEPTH, 512, number of 256-bit lines; power of two, at least 2
- clk_i  input  1  clock; all state changes on rising edge
- rst_i  input  1  asynchronous, active-low reset
- enable_i  input  1  request valid; held high by the cache until ack_o is seen
- write_i  input  1  1 = line write, 0 = line read; qualified by enable_i
- addr_i  input  32  byte address; bits [4:0] ignored; line index = addr_i[5 +: log2(DEPTH)]; higher bits ignored (aliasing)
- data_i  input  256  write line data
- ack_o  output  1  request complete; high for exactly one cycle per accepted request
- data_o  output  256  read line data; valid while ack_o is high for a read

## Operation
- States: IDLE, BUSY, ACK.
- IDLE: if enable_i sampled high -> capture addr_i line index, write_i, data_i into request registers; load counter with LATENCY-1; go BUSY. Else stay IDLE.
- BUSY: enable_i, write_i, addr_i, data_i ignored (captured values used). If counter != 0 -> decrement, stay. If counter == 0 -> go ACK, set ack_o; for write commit captured data to array[index]; for read load data_o from array[index].
- ACK: clear ack_o; go IDLE. enable_i ignored in ACK, so a request still asserted in the ack cycle is not accepted twice.
- data_o holds the last completed read value; writes never change data_o.
- Array contents are not reset; uninitialized lines read X. Bench preloads the array hierarchically.
- Read after write to same line returns the written data.
- Index wrap: addresses differing only above bit 5+log2(DEPTH)-1 hit the same line.
- Counter width is 8 bits; no arithmetic on addresses beyond bit slicing.

## Timing
- Reset (asynchronous assertion, any state): state=IDLE, counter=0, ack_o=0, data_o=0. An in-flight request is dropped: no array write, no ack. Array contents retained.
- Request accepted at rising edge N (IDLE, enable_i=1).
- ack_o high from edge N+LATENCY to edge N+LATENCY+1; write commit and data_o update at edge N+LATENCY.
- LATENCY=1: ack_o high from edge N+1 to N+2.
- Earliest next acceptance: edge N+LATENCY+2 (first IDLE sample after ACK). Minimum back-to-back spacing LATENCY+2 cycles.
- Deasserting enable_i during BUSY does not abort; request still completes and acks.
- No combinational paths from inputs to outputs.

## Test plan
- Reset: rst_i low mid-simulation with state BUSY -> ack_o=0, data_o=0 immediately; after release, no ack appears for the dropped request; preloaded array line 3 unchanged.
- Read, LATENCY=10: preload line 5 = 256'hA5...A5; enable_i=1, write_i=0, addr_i=32'h000000A0 accepted at edge N -> ack_o high only between edges N+10 and N+11, data_o=256'hA5...A5, held after ack.
- Write then read: write line at addr 32'h00000140 with 256'h1234..., then read same address -> read ack returns 256'h1234...; data_o unchanged during the write's ack cycle.
- Held enable: keep enable_i=1 continuously with same read address for 40 cycles, LATENCY=10 -> acks at N+10, N+22, N+34 (spacing 12), never two consecutive ack cycles.
- Mid-flight change: after acceptance of write to line 2, change addr_i to line 7 and drop enable_i at N+3 -> line 2 written, line 7 untouched, single ack at N+10.
- Aliasing and LATENCY=1: DEPTH=512, write to 32'h00004020 then read 32'h00000020 -> returns written data; each ack exactly one cycle after acceptance edge +1.

Source files
------------

// File: rtl/data_memory_line.sv
// Line-granular data memory responder for the data cache. Each accepted
// 256-bit line request completes after a fixed LATENCY with a one-cycle ack.
module data_memory_line #(
   parameter int unsigned LATENCY = 10,
   parameter int unsigned DEPTH   = 512
) (
   input  logic         clk_i,
   input  logic         rst_i,
   input  logic         enable_i,
   input  logic         write_i,
   input  logic [31:0]  addr_i,
   input  logic [255:0] data_i,
   output logic         ack_o,
   output logic [255:0] data_o
);

   localparam int unsigned IDX_W = $clog2(DEPTH);

   typedef enum logic [1:0] {IDLE, BUSY, ACK} state_e;

   state_e             state_q, state_d;
   logic [7:0]         cnt_q, cnt_d;
   logic [IDX_W-1:0]   idx_q, idx_d;
   logic               wr_q, wr_d;
   logic [255:0]       wdata_q, wdata_d;
   logic [255:0]       rdata_q, rdata_d;
   logic               mem_we;

   // Line storage; deliberately not reset so contents survive rst_i.
   logic [255:0]       mem_q [DEPTH];

   // Byte offset and aliased upper address bits carry no meaning here.
   logic unused_addr;
   assign unused_addr = ^{addr_i[31:5+IDX_W], addr_i[4:0]};

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      idx_d   = idx_q;
      wr_d    = wr_q;
      wdata_d = wdata_q;
      rdata_d = rdata_q;
      mem_we  = 1'b0;
      case (state_q)
         IDLE: begin
            if (enable_i) begin
               idx_d   = addr_i[5 +: IDX_W];
               wr_d    = write_i;
               wdata_d = data_i;
               cnt_d   = 8'(LATENCY - 1);
               state_d = BUSY;
            end
         end
         BUSY: begin
            if (cnt_q != 8'd0) begin
               cnt_d = cnt_q - 8'd1;
            end else begin
               state_d = ACK;
               mem_we  = wr_q;
               if (!wr_q) rdata_d = mem_q[idx_q];
            end
         end
         ACK:     state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state_q <= IDLE;
         cnt_q   <= 8'd0;
         idx_q   <= '0;
         wr_q    <= 1'b0;
         wdata_q <= '0;
         rdata_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         wr_q    <= wr_d;
         wdata_q <= wdata_d;
         rdata_q <= rdata_d;
      end
   end

   // mem_we is only ever set from BUSY, so a reset drops any pending commit.
   always_ff @(posedge clk_i) begin
      if (mem_we) mem_q[idx_q] <= wdata_q;
   end

   assign ack_o  = (state_q == ACK);
   assign data_o = rdata_q;

endmodule

// File: tb/tb_data_memory_line.sv
// Directed bench for data_memory_line: a LATENCY=10 instance for timing,
// hold, mid-flight and reset cases, and a LATENCY=1 instance for aliasing.
module tb_data_memory_line;

   logic         clk;
   logic         rst;
   logic [1:0]   en, we, ack;
   logic [31:0]  addr [2];
   logic [255:0] din  [2];
   logic [255:0] dout [2];
   logic [255:0] exp_do [2];

   int n_vec  = 0;
   int n_miss = 0;

   localparam logic [255:0] PAT_A5 = {32{8'hA5}};
   localparam logic [255:0] PAT_C3 = {32{8'hC3}};
   localparam logic [255:0] PAT_22 = {32{8'h22}};
   localparam logic [255:0] PAT_77 = {32{8'h77}};
   localparam logic [255:0] PAT_12 = {8{32'h12345678}};
   localparam logic [255:0] PAT_BE = {16{16'hBEEF}};
   localparam logic [255:0] PAT_FF = {32{8'hFF}};
   localparam logic [255:0] PAT_DA = {8{32'hDA7A_0001}};

   data_memory_line #(.LATENCY(10), .DEPTH(512)) dut (
      .clk_i(clk), .rst_i(rst), .enable_i(en[0]), .write_i(we[0]),
      .addr_i(addr[0]), .data_i(din[0]), .ack_o(ack[0]), .data_o(dout[0])
   );

   data_memory_line #(.LATENCY(1), .DEPTH(512)) dut1 (
      .clk_i(clk), .rst_i(rst), .enable_i(en[1]), .write_i(we[1]),
      .addr_i(addr[1]), .data_i(din[1]), .ack_o(ack[1]), .data_o(dout[1])
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_miss++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // One request with enable held until ack; checks ack and data_o every cycle.
   task automatic do_req(input int sel, input logic w, input logic [31:0] a,
                         input logic [255:0] d, input logic [255:0] exp_rd,
                         input string tag);
      int lat;
      lat = (sel == 1) ? 1 : 10;
      en[sel] = 1'b1; we[sel] = w; addr[sel] = a; din[sel] = d;
      tick;
      chk({tag, "_acc_ack"}, 256'(ack[sel]), 256'(0));
      for (int j = 1; j <= lat; j++) begin
         tick;
         chk({tag, "_ack"}, 256'(ack[sel]), 256'(j == lat));
         if (j == lat) begin
            if (!w) exp_do[sel] = exp_rd;
            en[sel] = 1'b0;
         end
         chk({tag, "_data"}, dout[sel], exp_do[sel]);
      end
      tick;
      chk({tag, "_post_ack"}, 256'(ack[sel]), 256'(0));
      chk({tag, "_post_data"}, dout[sel], exp_do[sel]);
   endtask

   initial begin
      rst = 1'b0;
      en = '0; we = '0;
      addr[0] = '0; addr[1] = '0; din[0] = '0; din[1] = '0;
      exp_do[0] = '0; exp_do[1] = '0;
      dut.mem_q[2] = PAT_22;
      dut.mem_q[3] = PAT_C3;
      dut.mem_q[5] = PAT_A5;
      dut.mem_q[7] = PAT_77;
      #12;
      chk("rst_ack0",  256'(ack[0]), 256'(0));
      chk("rst_data0", dout[0], 256'(0));
      chk("rst_ack1",  256'(ack[1]), 256'(0));
      chk("rst_data1", dout[1], 256'(0));
      @(negedge clk);
      rst = 1'b1;

      // Read of preloaded line 5.
      do_req(0, 1'b0, 32'h0000_00A0, '0, PAT_A5, "rd5");

      // Write then read; data_o must not move on the write's ack.
      do_req(0, 1'b1, 32'h0000_0140, PAT_12, '0, "wr10");
      do_req(0, 1'b0, 32'h0000_0140, '0, PAT_12, "rd10");
      do_req(0, 1'b0, 32'h0000_00A0, '0, PAT_A5, "rd5b");

      // Enable held high: acks spaced LATENCY+2 apart, never back to back.
      en[0] = 1'b1; we[0] = 1'b0; addr[0] = 32'h0000_00A0;
      tick;
      for (int c = 1; c <= 40; c++) begin
         tick;
         chk("hold_ack", 256'(ack[0]), 256'(c == 10 || c == 22 || c == 34));
         chk("hold_data", dout[0], PAT_A5);
         if (c == 35) en[0] = 1'b0;
      end

      // Inputs change mid-flight: captured write to line 2 must win.
      en[0] = 1'b1; we[0] = 1'b1; addr[0] = 32'h0000_0040; din[0] = PAT_BE;
      tick;
      for (int j = 1; j <= 12; j++) begin
         tick;
         if (j == 3) begin
            addr[0] = 32'h0000_00E0; din[0] = PAT_FF; en[0] = 1'b0; we[0] = 1'b0;
         end
         chk("mid_ack", 256'(ack[0]), 256'(j == 10));
      end
      do_req(0, 1'b0, 32'h0000_0040, '0, PAT_BE, "mid_rd2");
      do_req(0, 1'b0, 32'h0000_00E0, '0, PAT_77, "mid_rd7");

      // Reset while a write to line 3 is in flight.
      en[0] = 1'b1; we[0] = 1'b1; addr[0] = 32'h0000_0060; din[0] = PAT_FF;
      tick;
      for (int j = 0; j < 4; j++) tick;
      #2 rst = 1'b0;
      #1;
      chk("mid_rst_ack",  256'(ack[0]), 256'(0));
      chk("mid_rst_data", dout[0], 256'(0));
      exp_do[0] = '0; exp_do[1] = '0;
      en[0] = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      for (int j = 1; j <= 15; j++) begin
         tick;
         chk("drop_ack", 256'(ack[0]), 256'(0));
      end
      do_req(0, 1'b0, 32'h0000_0060, '0, PAT_C3, "rd3_kept");

      // LATENCY=1 with aliased addresses onto line 1.
      do_req(1, 1'b1, 32'h0000_4020, PAT_DA, '0, "al_wr");
      do_req(1, 1'b0, 32'h0000_0020, '0, PAT_DA, "al_rd");

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
